arp_rx_counter: RTL and testbench

Passive ARP monitor on the 512-bit RX AXI-Stream inside the 322 MHz box. It classifies each received frame, counts ARP requests and replies addressed to this node, and drives `regRequestCount`/`regReplyCount` and their valid flags into `box_322_config_register`. It takes `local_addr`/`local_mac` from that block as its match values. It only taps the stream: it never drives `tready` and never alters data.

---
 rtl/arp_rx_counter.sv | 196 +++++++++++++++++++
 tb/tb_arp_rx_counter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_rx_counter.sv
// ---------------------------------------------------------------------------
// arp_rx_counter
//
// Passive ARP monitor on a 512-bit receive AXI-Stream. Each frame is
// classified from its first (header) beat. ARP requests and replies that
// target this node are counted in two saturating counters, each with a
// sticky valid flag. The module only observes the stream. It never drives
// tready and never touches the data.
//
// Ports
//   axil_aclk            clock
//   axil_aresetn         asynchronous active-low reset
//   s_axis_tvalid/tready stream handshake (tap); beat = tvalid & tready
//   s_axis_tdata[511:0]  frame data, byte n at [8n+7:8n], byte 0 first on wire
//   s_axis_tkeep[63:0]   byte enables
//   s_axis_tlast         last beat of frame
//   local_addr[31:0]     node IPv4 address ([31:24] first on wire)
//   local_mac[47:0]      node MAC address ([47:40] first on wire)
//   cnt_clr              one-cycle pulse: clear counters and valid flags
//   regRequestCount      matched ARP request count (saturating)
//   regReplyCount        matched ARP reply count (saturating)
//   regRequestCount_vld  sticky, set on first request count after reset/clear
//   regReplyCount_vld    sticky, set on first reply count after reset/clear
// ---------------------------------------------------------------------------
module arp_rx_counter #(
    parameter int CNT_W = 16
) (
    input  logic             axil_aclk,
    input  logic             axil_aresetn,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tready,
    input  logic [511:0]     s_axis_tdata,
    input  logic [63:0]      s_axis_tkeep,
    input  logic             s_axis_tlast,
    input  logic [31:0]      local_addr,
    input  logic [47:0]      local_mac,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] regRequestCount,
    output logic [CNT_W-1:0] regReplyCount,
    output logic             regRequestCount_vld,
    output logic             regReplyCount_vld
);

    typedef enum logic {
        FIRST = 1'b0,
        BODY  = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic pend_req_reg, pend_req_next;
    logic pend_rep_reg, pend_rep_next;
    logic commit_req_reg, commit_req_next;
    logic commit_rep_reg, commit_rep_next;

    logic [CNT_W-1:0] req_cnt_reg, rep_cnt_reg;
    logic             req_vld_reg, rep_vld_reg;

    logic beat;
    assign beat = s_axis_tvalid & s_axis_tready;

    // -----------------------------------------------------------------------
    // Header field extraction. Multi-byte fields are big-endian on the wire,
    // so byte 0 of a field lands in the field's most significant octet.
    // -----------------------------------------------------------------------
    logic [47:0] dst_mac;
    logic [31:0] tpa;
    logic [15:0] ether_type;
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_dst_mac
            assign dst_mac[47-8*gi -: 8] = s_axis_tdata[8*gi +: 8];
        end
        for (gi = 0; gi < 4; gi++) begin : g_tpa
            assign tpa[31-8*gi -: 8] = s_axis_tdata[8*(38+gi) +: 8];
        end
    endgenerate

    assign ether_type = {s_axis_tdata[8*12 +: 8], s_axis_tdata[8*13 +: 8]};
    assign htype      = {s_axis_tdata[8*14 +: 8], s_axis_tdata[8*15 +: 8]};
    assign ptype      = {s_axis_tdata[8*16 +: 8], s_axis_tdata[8*17 +: 8]};
    assign hlen       = s_axis_tdata[8*18 +: 8];
    assign plen       = s_axis_tdata[8*19 +: 8];
    assign oper       = {s_axis_tdata[8*20 +: 8], s_axis_tdata[8*21 +: 8]};

    // Sender addresses, target MAC, the rest of the beat and the upper byte
    // enables do not take part in classification.
    logic unused_bits;
    assign unused_bits = &{1'b0, s_axis_tdata[511:336], s_axis_tdata[303:176],
                           s_axis_tkeep[63:42]};

    // -----------------------------------------------------------------------
    // Classification of the current beat as if it were a header beat.
    // -----------------------------------------------------------------------
    logic fmt_ok, dst_ok, tpa_ok, hit_req, hit_rep;

    assign fmt_ok = (&s_axis_tkeep[41:0])
                  && (ether_type == 16'h0806)
                  && (htype == 16'h0001)
                  && (ptype == 16'h0800)
                  && (hlen == 8'd6)
                  && (plen == 8'd4);
    assign dst_ok  = (dst_mac == 48'hFFFF_FFFF_FFFF) || (dst_mac == local_mac);
    assign tpa_ok  = (tpa == local_addr);
    assign hit_req = fmt_ok && dst_ok && tpa_ok && (oper == 16'd1);
    assign hit_rep = fmt_ok && dst_ok && tpa_ok && (oper == 16'd2);

    // -----------------------------------------------------------------------
    // Frame FSM, pending flags and commit pulses
    // -----------------------------------------------------------------------
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            state_reg      <= FIRST;
            pend_req_reg   <= 1'b0;
            pend_rep_reg   <= 1'b0;
            commit_req_reg <= 1'b0;
            commit_rep_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pend_req_reg   <= pend_req_next;
            pend_rep_reg   <= pend_rep_next;
            commit_req_reg <= commit_req_next;
            commit_rep_reg <= commit_rep_next;
        end
    end

    always_comb begin
        logic cur_req;
        logic cur_rep;
        state_next      = state_reg;
        pend_req_next   = pend_req_reg;
        pend_rep_next   = pend_rep_reg;
        commit_req_next = 1'b0;
        commit_rep_next = 1'b0;
        // Header beat gets its verdict from the live classifier. Later beats
        // carry forward the verdict that was latched on the header beat.
        cur_req = (state_reg == FIRST) ? hit_req : pend_req_reg;
        cur_rep = (state_reg == FIRST) ? hit_rep : pend_rep_reg;
        if (beat) begin
            if (s_axis_tlast) begin
                state_next      = FIRST;
                commit_req_next = cur_req;
                commit_rep_next = cur_rep;
                pend_req_next   = 1'b0;
                pend_rep_next   = 1'b0;
            end else begin
                state_next    = BODY;
                pend_req_next = cur_req;
                pend_rep_next = cur_rep;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Saturating counters with sticky valid flags. A clear in the same cycle
    // as a commit discards that commit.
    // -----------------------------------------------------------------------
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            req_cnt_reg <= '0;
            rep_cnt_reg <= '0;
            req_vld_reg <= 1'b0;
            rep_vld_reg <= 1'b0;
        end else if (cnt_clr) begin
            req_cnt_reg <= '0;
            rep_cnt_reg <= '0;
            req_vld_reg <= 1'b0;
            rep_vld_reg <= 1'b0;
        end else begin
            if (commit_req_reg) begin
                if (req_cnt_reg != {CNT_W{1'b1}}) begin
                    req_cnt_reg <= req_cnt_reg + 1'b1;
                end
                req_vld_reg <= 1'b1;
            end
            if (commit_rep_reg) begin
                if (rep_cnt_reg != {CNT_W{1'b1}}) begin
                    rep_cnt_reg <= rep_cnt_reg + 1'b1;
                end
                rep_vld_reg <= 1'b1;
            end
        end
    end

    assign regRequestCount     = req_cnt_reg;
    assign regReplyCount       = rep_cnt_reg;
    assign regRequestCount_vld = req_vld_reg;
    assign regReplyCount_vld   = rep_vld_reg;

endmodule

// File: tb/tb_arp_rx_counter.sv
// ---------------------------------------------------------------------------
// tb_arp_rx_counter
//
// Self-checking bench for arp_rx_counter. Frames are described by their
// field values. A behavioural model decides from those fields whether each
// frame is a counted request, a counted reply, or ignored. The model then
// keeps saturating counts that are compared with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_arp_rx_counter;

    localparam int          CNT_W   = 16;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] LADDR   = 32'h0A00_0001;
    localparam logic [47:0] LMAC    = 48'h0011_2233_4455;

    logic             axil_aclk = 1'b0;
    logic             axil_aresetn;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [511:0]     s_axis_tdata;
    logic [63:0]      s_axis_tkeep;
    logic             s_axis_tlast;
    logic [31:0]      local_addr;
    logic [47:0]      local_mac;
    logic             cnt_clr;
    logic [CNT_W-1:0] regRequestCount;
    logic [CNT_W-1:0] regReplyCount;
    logic             regRequestCount_vld;
    logic             regReplyCount_vld;

    always #5 axil_aclk = ~axil_aclk;

    arp_rx_counter #(.CNT_W(CNT_W)) dut (
        .axil_aclk           (axil_aclk),
        .axil_aresetn        (axil_aresetn),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tready       (s_axis_tready),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tkeep        (s_axis_tkeep),
        .s_axis_tlast        (s_axis_tlast),
        .local_addr          (local_addr),
        .local_mac           (local_mac),
        .cnt_clr             (cnt_clr),
        .regRequestCount     (regRequestCount),
        .regReplyCount       (regReplyCount),
        .regRequestCount_vld (regRequestCount_vld),
        .regReplyCount_vld   (regReplyCount_vld)
    );

    typedef struct packed {
        logic [47:0] dst;
        logic [15:0] etype;
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [7:0]  plen;
        logic [15:0] oper;
        logic [31:0] tpa;
        logic [63:0] keep;
    } frame_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    int model_req = 0;
    int model_rep = 0;
    bit model_req_vld = 1'b0;
    bit model_rep_vld = 1'b0;

    // ---------------- frame construction ----------------
    function automatic frame_t good_frame(logic [15:0] op);
        frame_t f;
        f.dst   = 48'hFFFF_FFFF_FFFF;
        f.etype = 16'h0806;
        f.htype = 16'h0001;
        f.ptype = 16'h0800;
        f.hlen  = 8'd6;
        f.plen  = 8'd4;
        f.oper  = op;
        f.tpa   = LADDR;
        f.keep  = '1;
        return f;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [511:0] make_hdr(frame_t f);
        logic [511:0] d;
        d = rand512();
        for (int i = 0; i < 6; i++) d[8*i +: 8] = f.dst[47-8*i -: 8];
        d[8*12 +: 8] = f.etype[15:8];
        d[8*13 +: 8] = f.etype[7:0];
        d[8*14 +: 8] = f.htype[15:8];
        d[8*15 +: 8] = f.htype[7:0];
        d[8*16 +: 8] = f.ptype[15:8];
        d[8*17 +: 8] = f.ptype[7:0];
        d[8*18 +: 8] = f.hlen;
        d[8*19 +: 8] = f.plen;
        d[8*20 +: 8] = f.oper[15:8];
        d[8*21 +: 8] = f.oper[7:0];
        for (int i = 0; i < 4; i++) d[8*(38+i) +: 8] = f.tpa[31-8*i -: 8];
        return d;
    endfunction

    // ---------------- reference model ----------------
    // 1 = counted request, 2 = counted reply, 0 = ignored
    function automatic int classify(frame_t f);
        bit arp_ok;
        bit addressed;
        arp_ok = (f.keep[41:0] == {42{1'b1}}) && f.etype == 16'h0806 &&
                 f.htype == 16'h0001 && f.ptype == 16'h0800 &&
                 f.hlen == 8'd6 && f.plen == 8'd4;
        addressed = (f.dst == 48'hFFFF_FFFF_FFFF || f.dst == LMAC) && f.tpa == LADDR;
        if (!(arp_ok && addressed)) return 0;
        if (f.oper == 16'd1) return 1;
        if (f.oper == 16'd2) return 2;
        return 0;
    endfunction

    task automatic model_frame(frame_t f);
        int k;
        k = classify(f);
        if (k == 1) begin
            model_req = (model_req < CNT_MAX) ? model_req + 1 : CNT_MAX;
            model_req_vld = 1'b1;
        end else if (k == 2) begin
            model_rep = (model_rep < CNT_MAX) ? model_rep + 1 : CNT_MAX;
            model_rep_vld = 1'b1;
        end
    endtask

    task automatic model_clear();
        model_req = 0;
        model_rep = 0;
        model_req_vld = 1'b0;
        model_rep_vld = 1'b0;
    endtask

    // ---------------- stimulus drivers (called at negedge) ----------------
    task automatic drive_beat(logic [511:0] d, logic [63:0] k, logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tready = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = last;
        @(negedge axil_aclk);
    endtask

    // valid held with ready low: must not be taken as a beat (tlast=1 on purpose)
    task automatic stall(int n);
        s_axis_tvalid = 1'b1;
        s_axis_tready = 1'b0;
        s_axis_tdata  = rand512();
        s_axis_tlast  = 1'b1;
        repeat (n) @(negedge axil_aclk);
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'($urandom_range(0, 1));
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(frame_t f, int nbeats, int gap);
        for (int b = 0; b < nbeats; b++) begin
            if (b > 0 && gap > 0) stall(gap);
            if (b == 0) drive_beat(make_hdr(f), f.keep, nbeats == 1);
            else        drive_beat(rand512(), '1, b == nbeats - 1);
        end
        model_frame(f);
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        @(negedge axil_aclk);
        cnt_clr = 1'b0;
        model_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        axil_aresetn = 1'b0;
        #1;
        checks++;
        if ({regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld} !== '0) begin
            errors++;
            $display("FAIL reset_async got req=%0h/%0b rep=%0h/%0b exp all 0",
                     regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld);
        end
        repeat (3) @(negedge axil_aclk);
        axil_aresetn = 1'b1;
        repeat (2) @(negedge axil_aclk);
        checks++;
        if ({regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld} !== '0) begin
            errors++;
            $display("FAIL reset_release got req=%0h/%0b rep=%0h/%0b exp all 0",
                     regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld);
        end
        $display("test_reset: outputs checked during and after reset");
    endtask

    task automatic test_single_request();
        send_frame(good_frame(16'd1), 1, 0);
        idle();
        // one cycle after the beat: commit registered, counter not yet updated
        checks++;
        if ({regRequestCount, regRequestCount_vld} !== {CNT_W'(0), 1'b0}) begin
            errors++;
            $display("FAIL single_req_T+1 got req=%0h/%0b exp 0/0",
                     regRequestCount, regRequestCount_vld);
        end
        @(negedge axil_aclk);
        checks++;
        if ({regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld}
            !== {CNT_W'(1), 1'b1, CNT_W'(0), 1'b0}) begin
            errors++;
            $display("FAIL single_req_T+2 got req=%0h/%0b rep=%0h/%0b exp req=1/1 rep=0/0",
                     regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld);
        end
        $display("test_single_request: req=%0h vld=%0b", regRequestCount, regRequestCount_vld);
    endtask

    task automatic test_two_beat_reply();
        frame_t f;
        f = good_frame(16'd2);
        f.dst = LMAC;
        send_frame(f, 2, 3);
        idle();
        checks++;
        if ({regReplyCount, regReplyCount_vld} !== {CNT_W'(0), 1'b0}) begin
            errors++;
            $display("FAIL reply_T+1 got rep=%0h/%0b exp 0/0", regReplyCount, regReplyCount_vld);
        end
        @(negedge axil_aclk);
        checks++;
        if ({regRequestCount, regReplyCount, regReplyCount_vld} !== {CNT_W'(1), CNT_W'(1), 1'b1}) begin
            errors++;
            $display("FAIL reply_T+2 got req=%0h rep=%0h/%0b exp req=1 rep=1/1",
                     regRequestCount, regReplyCount, regReplyCount_vld);
        end
        $display("test_two_beat_reply: rep=%0h vld=%0b", regReplyCount, regReplyCount_vld);
    endtask

    task automatic test_rejects();
        frame_t f;
        pulse_clr();
        for (int v = 0; v < 5; v++) begin
            f = good_frame(16'd1);
            case (v)
                0: f.tpa   = 32'h0A00_0002;
                1: f.etype = 16'h0800;
                2: f.oper  = 16'd3;
                3: f.keep[41] = 1'b0;
                default: f.dst = 48'h0011_2233_4456;
            endcase
            send_frame(f, 1, 0);
            idle();
            repeat (3) @(negedge axil_aclk);
            checks++;
            if ({regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld} !== '0) begin
                errors++;
                $display("FAIL reject_%0d got req=%0h/%0b rep=%0h/%0b exp all 0", v,
                         regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld);
            end
            $display("test_rejects: variant %0d req=%0h rep=%0h", v, regRequestCount, regReplyCount);
        end
    endtask

    task automatic test_saturation_and_clear();
        pulse_clr();
        for (int i = 0; i < CNT_MAX + 2; i++) send_frame(good_frame(16'd1), 1, 0);
        idle();
        repeat (3) @(negedge axil_aclk);
        checks++;
        if ({regRequestCount, regRequestCount_vld} !== {CNT_W'(model_req), model_req_vld}) begin
            errors++;
            $display("FAIL saturate got req=%0h/%0b exp %0h/%0b",
                     regRequestCount, regRequestCount_vld, CNT_W'(model_req), model_req_vld);
        end
        $display("test_saturation: %0d frames, req=%0h", CNT_MAX + 2, regRequestCount);
        // one more request; clear lands in the same cycle as its commit
        send_frame(good_frame(16'd1), 1, 0);
        idle();
        pulse_clr();
        checks++;
        if ({regRequestCount, regRequestCount_vld} !== {CNT_W'(0), 1'b0}) begin
            errors++;
            $display("FAIL clr_vs_commit got req=%0h/%0b exp 0/0",
                     regRequestCount, regRequestCount_vld);
        end
        repeat (2) @(negedge axil_aclk);
        checks++;
        if ({regRequestCount, regRequestCount_vld} !== {CNT_W'(0), 1'b0}) begin
            errors++;
            $display("FAIL clr_count_lost got req=%0h/%0b exp 0/0",
                     regRequestCount, regRequestCount_vld);
        end
        $display("test_clear: req=%0h vld=%0b", regRequestCount, regRequestCount_vld);
    endtask

    task automatic test_reset_midframe();
        send_frame(good_frame(16'd1), 1, 0);
        idle();
        repeat (2) @(negedge axil_aclk);
        checks++;
        if ({regRequestCount, regRequestCount_vld} !== {CNT_W'(1), 1'b1}) begin
            errors++;
            $display("FAIL midframe_pre got req=%0h/%0b exp 1/1", regRequestCount, regRequestCount_vld);
        end
        // first beat of a 3-beat valid request, then reset during beat 2
        drive_beat(make_hdr(good_frame(16'd1)), '1, 1'b0);
        s_axis_tdata = rand512();
        s_axis_tlast = 1'b0;
        #2;
        axil_aresetn = 1'b0;
        #1;
        checks++;
        if ({regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld} !== '0) begin
            errors++;
            $display("FAIL midframe_reset got req=%0h/%0b rep=%0h/%0b exp all 0",
                     regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld);
        end
        @(negedge axil_aclk);
        idle();
        @(negedge axil_aclk);
        axil_aresetn = 1'b1;
        model_clear();
        @(negedge axil_aclk);
        send_frame(good_frame(16'd1), 1, 0);
        idle();
        repeat (2) @(negedge axil_aclk);
        checks++;
        if ({regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld}
            !== {CNT_W'(1), 1'b1, CNT_W'(0), 1'b0}) begin
            errors++;
            $display("FAIL midframe_next got req=%0h/%0b rep=%0h/%0b exp req=1/1 rep=0/0",
                     regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld);
        end
        $display("test_reset_midframe: req=%0h rep=%0h", regRequestCount, regReplyCount);
    endtask

    task automatic test_back_to_back();
        frame_t f;
        pulse_clr();
        for (int i = 0; i < 20; i++) begin
            f = good_frame((i % 2 == 0) ? 16'd1 : 16'd2);
            if ($urandom_range(0, 1) == 1) f.dst = LMAC;
            send_frame(f, 1, 0);
        end
        idle();
        repeat (3) @(negedge axil_aclk);
        checks++;
        if ({regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld}
            !== {CNT_W'(10), 1'b1, CNT_W'(10), 1'b1}) begin
            errors++;
            $display("FAIL back_to_back got req=%0h/%0b rep=%0h/%0b exp req=a/1 rep=a/1",
                     regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld);
        end
        $display("test_back_to_back: req=%0d rep=%0d", regRequestCount, regReplyCount);
    endtask

    task automatic test_random();
        frame_t f;
        int fault, nb, gap;
        for (int i = 0; i < 40; i++) begin
            f = good_frame(16'($urandom_range(1, 2)));
            if ($urandom_range(0, 1) == 1) f.dst = LMAC;
            fault = $urandom_range(0, 8);
            case (fault)
                3: f.etype = 16'($urandom_range(0, 16'hFFFF)) | 16'h1000;
                4: f.tpa   = LADDR ^ (32'h1 << $urandom_range(0, 31));
                5: f.oper  = 16'($urandom_range(3, 16'hFFFF));
                6: f.keep[$urandom_range(0, 41)] = 1'b0;
                7: f.dst   = LMAC ^ (48'h1 << $urandom_range(0, 47));
                8: f.hlen  = 8'($urandom_range(7, 255));
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0) f.keep[63:42] = '0;
            nb  = $urandom_range(1, 3);
            gap = $urandom_range(0, 2);
            send_frame(f, nb, gap);
            idle();
            repeat (2) @(negedge axil_aclk);
            checks++;
            if ({regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld}
                !== {CNT_W'(model_req), model_req_vld, CNT_W'(model_rep), model_rep_vld}) begin
                errors++;
                $display("FAIL random_%0d got req=%0h/%0b rep=%0h/%0b exp req=%0h/%0b rep=%0h/%0b",
                         i, regRequestCount, regRequestCount_vld, regReplyCount, regReplyCount_vld,
                         CNT_W'(model_req), model_req_vld, CNT_W'(model_rep), model_rep_vld);
            end
            $display("test_random: frame %0d fault=%0d beats=%0d req=%0d rep=%0d",
                     i, fault, nb, regRequestCount, regReplyCount);
        end
    endtask

    initial begin
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        local_addr    = LADDR;
        local_mac     = LMAC;
        cnt_clr       = 1'b0;
        axil_aresetn  = 1'b0;
        @(negedge axil_aclk);
        test_reset();
        test_single_request();
        test_two_beat_reply();
        test_rejects();
        test_saturation_and_clear();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
